card_dealer: RTL and testbench

CARD_DEALER -- requirements
Module: card_dealer

---
 rtl/card_dealer.sv | 130 +++++++++++++
 tb/tb_card_dealer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// card_dealer: LFSR-driven card draw from an infinite or finite deck with rejection sampling
module card_dealer #(
    parameter int          CARD_W    = 4,
    parameter int          RANK_MAX  = 10,
    parameter int          COPIES    = 4,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 64
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     req,
    input  logic [CARD_W-1:0]                        lo,
    input  logic [CARD_W-1:0]                        hi,
    input  logic                                     no_replace,
    input  logic                                     shuffle,
    output logic                                     ready,
    output logic                                     valid,
    output logic [CARD_W-1:0]                        card,
    output logic                                     err,
    output logic [$clog2(RANK_MAX*COPIES+1)-1:0]     remaining
);
    localparam int CNT_W = $clog2(COPIES + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int REM_W = $clog2(RANK_MAX * COPIES + 1);
    localparam int NR    = 2 ** CARD_W;
    localparam logic [REM_W-1:0]  FULL = REM_W'(RANK_MAX * COPIES);
    localparam logic [CARD_W-1:0] RMAX = CARD_W'(RANK_MAX);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] DRAW  = 2'd2;

    logic [1:0]        state;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_next;
    logic [CARD_W-1:0] lo_q;
    logic [CARD_W-1:0] hi_q;
    logic              nr_q;
    logic [TRY_W-1:0]  tries;
    logic [CNT_W-1:0]  cnt [1:RANK_MAX];
    logic [NR-1:0]     elig;
    logic [CARD_W-1:0] low;
    logic [CARD_W-1:0] cand;
    logic [CARD_W-1:0] pick;
    logic              hit;
    logic              take;
    logic              bad;

    // a rank is eligible if it is legal, inside the captured bounds and (in finite mode) still in the deck
    for (genvar g = 0; g < NR; g++) begin : g_elig
        if (g >= 1 && g <= RANK_MAX) begin : g_rank
            assign elig[g] = lo_q <= CARD_W'(g) && CARD_W'(g) <= hi_q && (!nr_q || cnt[g] != '0);
        end else begin : g_none
            assign elig[g] = 1'b0;
        end
    end

    // lowest eligible rank is the fallback once rejection sampling gives up
    always_comb begin
        low = '0;
        for (int i = NR - 1; i >= 0; i--) low = elig[i] ? CARD_W'(i) : low;
    end

    // candidate selection, LFSR step and the illegal/empty request test
    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        cand      = lfsr[CARD_W-1:0];
        hit       = elig[cand];
        take      = state == DRAW && (hit || tries == TRY_W'(MAX_TRIES - 1));
        pick      = hit ? cand : low;
        bad       = lo_q == '0 || lo_q > hi_q || hi_q > RMAX || !(|elig);
        ready     = state == IDLE;
    end

    // FSM, deck bookkeeping and result register
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= 1'b0;
            err       <= 1'b0;
            card      <= '0;
            lfsr      <= SEED;
            tries     <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            nr_q      <= 1'b0;
            remaining <= FULL;
            for (int r = 1; r <= RANK_MAX; r++) cnt[r] <= CNT_W'(COPIES);
        end else begin
            lfsr  <= lfsr_next;
            valid <= 1'b0;
            if (state == IDLE) begin
                if (shuffle) begin
                    remaining <= FULL;
                    for (int r = 1; r <= RANK_MAX; r++) cnt[r] <= CNT_W'(COPIES);
                end else if (req) begin
                    lo_q  <= lo;
                    hi_q  <= hi;
                    nr_q  <= no_replace;
                    state <= CHECK;
                end
            end else if (state == CHECK) begin
                tries <= '0;
                if (bad) begin
                    valid <= 1'b1;
                    err   <= 1'b1;
                    card  <= '0;
                    state <= IDLE;
                end else begin
                    state <= DRAW;
                end
            end else if (state == DRAW) begin
                if (take) begin
                    valid <= 1'b1;
                    err   <= 1'b0;
                    card  <= pick;
                    state <= IDLE;
                    if (nr_q) begin
                        remaining <= remaining - REM_W'(1);
                        for (int r = 1; r <= RANK_MAX; r++)
                            if (pick == CARD_W'(r)) cnt[r] <= cnt[r] - CNT_W'(1);
                    end
                end else begin
                    tries <= tries + TRY_W'(1);
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed self-checking bench for card_dealer with default parameters
module tb_card_dealer;
    logic       clock = 1'b0;
    logic       reset;
    logic       req;
    logic [3:0] lo;
    logic [3:0] hi;
    logic       no_replace;
    logic       shuffle;
    logic       ready;
    logic       valid;
    logic [3:0] card;
    logic       err;
    logic [5:0] remaining;

    int n_chk  = 0;
    int n_fail = 0;

    card_dealer dut (
        .clock(clock), .reset(reset), .req(req), .lo(lo), .hi(hi),
        .no_replace(no_replace), .shuffle(shuffle), .ready(ready),
        .valid(valid), .card(card), .err(err), .remaining(remaining)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // issue one request from IDLE at a negedge, scramble inputs after accept, wait for the result
    task automatic draw(input logic [3:0] l, input logic [3:0] h, input logic nr,
                        output logic [3:0] c, output logic e, output int lat);
        req = 1'b1; lo = l; hi = h; no_replace = nr;
        @(negedge clock);
        req = 1'b0; lo = 4'h0; hi = 4'hf; no_replace = ~nr;
        lat = 1;
        while (!valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        chk("valid_seen", valid, 1);
        c = card;
        e = err;
    endtask

    initial begin
        logic [3:0] c;
        logic       e;
        int         lat;
        int         hist [16];
        reset = 1'b1; req = 1'b0; lo = '0; hi = '0; no_replace = 1'b0; shuffle = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_card", card, 0);
        chk("rst_remaining", remaining, 40);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 100; i++) begin
            draw(4'd1, 4'd10, 1'b0, c, e, lat);
            chk("inf_err", e, 0);
            chk("inf_range", c >= 1 && c <= 10, 1);
            chk("inf_latency", lat >= 3 && lat <= 66, 1);
        end
        chk("inf_remaining", remaining, 40);

        for (int r = 0; r < 16; r++) hist[r] = 0;
        for (int i = 0; i < 40; i++) begin
            draw(4'd1, 4'd10, 1'b1, c, e, lat);
            chk("fin_err", e, 0);
            chk("fin_latency", lat >= 3 && lat <= 66, 1);
            hist[c]++;
            chk("fin_remaining", remaining, 39 - i);
        end
        for (int r = 1; r <= 10; r++) chk("fin_hist", hist[r], 4);
        chk("fin_hist_zero", hist[0] + hist[11] + hist[12] + hist[13] + hist[14] + hist[15], 0);
        draw(4'd1, 4'd10, 1'b1, c, e, lat);
        chk("empty_err", e, 1);
        chk("empty_card", c, 0);
        chk("empty_latency", lat, 2);

        shuffle = 1'b1;
        @(negedge clock);
        shuffle = 1'b0;
        chk("shuffle_remaining", remaining, 40);

        draw(4'd5, 4'd3, 1'b1, c, e, lat);
        chk("illegal_err", e, 1);
        chk("illegal_card", c, 0);
        chk("illegal_latency", lat, 2);
        chk("illegal_remaining", remaining, 40);
        draw(4'd0, 4'd5, 1'b0, c, e, lat);
        chk("lo_zero_err", e, 1);
        draw(4'd9, 4'd11, 1'b0, c, e, lat);
        chk("hi_over_err", e, 1);

        for (int i = 0; i < 4; i++) begin
            draw(4'd7, 4'd7, 1'b1, c, e, lat);
            chk("seven_err", e, 0);
            chk("seven_card", c, 7);
        end
        chk("seven_remaining", remaining, 36);
        draw(4'd7, 4'd7, 1'b1, c, e, lat);
        chk("seven_empty_err", e, 1);
        chk("seven_empty_card", c, 0);
        chk("seven_empty_remaining", remaining, 36);
        shuffle = 1'b1;
        @(negedge clock);
        shuffle = 1'b0;
        chk("reshuffle_remaining", remaining, 40);
        draw(4'd7, 4'd7, 1'b1, c, e, lat);
        chk("reshuffle_card", c, 7);
        chk("reshuffle_err", e, 0);
        chk("reshuffle_dec", remaining, 39);

        req = 1'b1; shuffle = 1'b1; lo = 4'd1; hi = 4'd10; no_replace = 1'b1;
        @(negedge clock);
        req = 1'b0; shuffle = 1'b0;
        chk("both_ready", ready, 1);
        chk("both_remaining", remaining, 40);
        repeat (3) begin
            @(negedge clock);
            chk("both_no_valid", valid, 0);
        end

        req = 1'b1; lo = 4'd1; hi = 4'd10; no_replace = 1'b1;
        @(negedge clock);
        req = 1'b0;
        chk("abort_busy", ready, 0);
        @(negedge clock);
        chk("abort_in_draw", valid, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_valid", valid, 0);
        repeat (3) begin
            @(negedge clock);
            chk("abort_no_valid", valid, 0);
        end
        chk("abort_ready", ready, 1);
        chk("abort_remaining", remaining, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
